execute_resolve_stage: RTL and testbench

//  Pipeline stage directly downstream of the ALU; registers ALU Result and the 6-bit Comparisons vector.

---
 rtl/trashbin_pkg.sv | 23 ++
 rtl/skid_buffer_2.sv | 46 ++++
 rtl/execute_resolve_stage.sv | 56 +++++
 tb/tb_execute_resolve_stage.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/trashbin_pkg.sv
// trashbin_pkg: shared opcode, comparison and branch encodings, the execute record type and the branch-resolution helper
package trashbin_pkg;
  localparam int XLEN = 32;
  localparam logic [1:0] OP_ALU = 2'b00, OP_BRANCH = 2'b01, OP_JAL = 2'b10, OP_JALR = 2'b11;
  localparam int CMP_EQ = 0, CMP_NE = 1, CMP_LTU = 2, CMP_LTS = 3, CMP_GEU = 4, CMP_GES = 5;
  localparam logic [2:0] BR_EQ = 3'b000, BR_NE = 3'b001, BR_LT = 3'b100, BR_GE = 3'b101, BR_LTU = 3'b110, BR_GEU = 3'b111;
  typedef struct packed {
    logic            wb_en;
    logic [4:0]      rd;
    logic [XLEN-1:0] wb_value;
    logic            redirect;
    logic [XLEN-1:0] target;
    logic            fault;
  } exec_record_t;
  function automatic logic br_taken(input logic [2:0] f, input logic [5:0] c);
    return f == BR_EQ  ? c[CMP_EQ]  :
           f == BR_NE  ? c[CMP_NE]  :
           f == BR_LT  ? c[CMP_LTS] :
           f == BR_GE  ? c[CMP_GES] :
           f == BR_LTU ? c[CMP_LTU] :
           f == BR_GEU ? c[CMP_GEU] : 1'b0;
  endfunction
endpackage

// File: rtl/skid_buffer_2.sv
// skid_buffer_2: 2-entry valid/ready buffer with registered o_ready, synchronous flush and async active-low reset (i_data/i_valid/o_ready in, o_data/o_valid/i_ready out)
module skid_buffer_2 #(
  parameter int W = 8
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_flush,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [W-1:0] i_data,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [W-1:0] o_data
);
  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;
  state_t r_state, w_next;
  logic [W-1:0] r_head, r_skid;
  logic r_ready, w_in, w_out;
  assign w_in = i_valid & r_ready;
  assign w_out = (r_state != EMPTY) & i_ready;
  always_comb begin
    w_next = r_state;
    w_next = i_flush           ? EMPTY :
             r_state == EMPTY  ? (w_in ? ONE : EMPTY) :
             r_state == ONE    ? (w_in && !w_out ? TWO : !w_in && w_out ? EMPTY : ONE) :
             (w_out ? ONE : TWO);
  end
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_state <= EMPTY;
      r_ready <= 1'b0;
      r_head  <= '0;
      r_skid  <= '0;
    end else begin
      r_state <= w_next;
      r_ready <= w_next != TWO;
      if (!i_flush) begin
        if ((r_state == EMPTY && w_in) || (r_state == ONE && w_in && w_out)) r_head <= i_data;
        else if (r_state == TWO && w_out) r_head <= r_skid;
        if (r_state == ONE && w_in && !w_out) r_skid <= i_data;
      end
    end
  assign o_ready = r_ready;
  assign o_valid = r_state != EMPTY;
  assign o_data = r_head;
endmodule

// File: rtl/execute_resolve_stage.sv
// execute_resolve_stage: resolves branches/jumps after the ALU and emits writeback and PC-redirect records through a 2-entry skid buffer
module execute_resolve_stage
  import trashbin_pkg::*;
#(
  parameter bit ALLOW_COMPRESSED = 1'b0
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_flush,
  input  logic            i_in_valid,
  output logic            o_in_ready,
  input  logic [XLEN-1:0] i_alu_result,
  input  logic [5:0]      i_comparisons,
  input  logic [1:0]      i_op,
  input  logic [2:0]      i_funct3,
  input  logic [XLEN-1:0] i_pc,
  input  logic [XLEN-1:0] i_imm,
  input  logic [4:0]      i_rd,
  output logic            o_out_valid,
  input  logic            i_out_ready,
  output logic            o_wb_enable,
  output logic [4:0]      o_wb_rd,
  output logic [XLEN-1:0] o_wb_value,
  output logic            o_redirect,
  output logic [XLEN-1:0] o_redirect_target,
  output logic            o_misaligned_fault
);
  exec_record_t w_rec, w_head;
  logic [XLEN-1:0] w_target;
  logic w_cand, w_fault, w_out_valid;
  assign w_target = i_op == OP_JALR ? i_alu_result & ~XLEN'(1) : i_pc + i_imm;
  assign w_cand = i_op[1] | (i_op == OP_BRANCH & br_taken(i_funct3, i_comparisons));
  assign w_fault = w_cand & (ALLOW_COMPRESSED ? w_target[0] : |w_target[1:0]);
  always_comb begin
    w_rec = '0;
    w_rec.fault = w_fault;
    w_rec.target = w_target;
    w_rec.redirect = w_cand & !w_fault;
    w_rec.rd = i_rd;
    w_rec.wb_value = i_op == OP_ALU ? i_alu_result : i_pc + XLEN'(4);
    w_rec.wb_en = i_op != OP_BRANCH && i_rd != 5'd0 && !w_fault;
  end
  skid_buffer_2 #(.W($bits(exec_record_t))) u_skid (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_flush(i_flush),
    .i_valid(i_in_valid), .o_ready(o_in_ready), .i_data(w_rec),
    .o_valid(w_out_valid), .i_ready(i_out_ready), .o_data(w_head)
  );
  // control flags are qualified by valid so a drained stage never shows stale enables
  assign o_out_valid = w_out_valid;
  assign o_wb_enable = w_out_valid & w_head.wb_en;
  assign o_redirect = w_out_valid & w_head.redirect;
  assign o_misaligned_fault = w_out_valid & w_head.fault;
  assign o_wb_rd = w_head.rd;
  assign o_wb_value = w_head.wb_value;
  assign o_redirect_target = w_head.target;
endmodule

// File: tb/tb_execute_resolve_stage.sv
// tb_execute_resolve_stage: directed self-checking bench for execute_resolve_stage
module tb_execute_resolve_stage;
  logic clk = 1'b0, rst_n = 1'b0, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic in_ready, out_valid, wb_enable, redirect, fault;
  logic [31:0] alu = '0, pc = '0, imm = '0, wb_value, target;
  logic [5:0] cmp = '0;
  logic [1:0] op = '0;
  logic [2:0] f3 = '0;
  logic [4:0] rd = '0, wb_rd;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  execute_resolve_stage dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush), .i_in_valid(in_valid), .o_in_ready(in_ready),
    .i_alu_result(alu), .i_comparisons(cmp), .i_op(op), .i_funct3(f3), .i_pc(pc), .i_imm(imm),
    .i_rd(rd), .o_out_valid(out_valid), .i_out_ready(out_ready), .o_wb_enable(wb_enable),
    .o_wb_rd(wb_rd), .o_wb_value(wb_value), .o_redirect(redirect), .o_redirect_target(target),
    .o_misaligned_fault(fault)
  );
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic drive(input logic [1:0] o, input logic [2:0] f, input logic [5:0] c,
                       input logic [31:0] p, input logic [31:0] i, input logic [31:0] a, input logic [4:0] r);
    op = o; f3 = f; cmp = c; pc = p; imm = i; alu = a; rd = r; in_valid = 1'b1;
  endtask
  initial begin
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_wb_value", wb_value, 32'd0);
    #3 rst_n = 1'b1;
    tick();
    chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
    // 1: ALU op
    out_ready = 1'b1;
    drive(2'b00, 3'b000, 6'd0, 32'h0, 32'h0, 32'h12345678, 5'd5);
    tick();
    chk("alu_valid", {31'd0, out_valid}, 32'd1);
    chk("alu_wb_en", {31'd0, wb_enable}, 32'd1);
    chk("alu_wb_value", wb_value, 32'h12345678);
    chk("alu_wb_rd", {27'd0, wb_rd}, 32'd5);
    chk("alu_redirect", {31'd0, redirect}, 32'd0);
    // 2: branches
    drive(2'b01, 3'b100, 6'b001010, 32'h100, 32'hFFFFFFF8, 32'h0, 5'd7);
    tick();
    chk("blt_redirect", {31'd0, redirect}, 32'd1);
    chk("blt_target", target, 32'hF8);
    chk("blt_wb_en", {31'd0, wb_enable}, 32'd0);
    f3 = 3'b101;
    tick();
    chk("bge_redirect", {31'd0, redirect}, 32'd0);
    f3 = 3'b001;
    tick();
    chk("bne_redirect", {31'd0, redirect}, 32'd1);
    f3 = 3'b110;
    tick();
    chk("bltu_redirect", {31'd0, redirect}, 32'd0);
    f3 = 3'b010; cmp = 6'b111111;
    tick();
    chk("f3_010_redirect", {31'd0, redirect}, 32'd0);
    // 3: jumps
    drive(2'b11, 3'b000, 6'd0, 32'h40, 32'h0, 32'h203, 5'd1);
    tick();
    chk("jalr_wb_value", wb_value, 32'h44);
    chk("jalr_target", target, 32'h202);
    chk("jalr_fault", {31'd0, fault}, 32'd1);
    chk("jalr_redirect", {31'd0, redirect}, 32'd0);
    chk("jalr_wb_en", {31'd0, wb_enable}, 32'd0);
    alu = 32'h205;
    tick();
    chk("jalr_ok_target", target, 32'h204);
    chk("jalr_ok_redirect", {31'd0, redirect}, 32'd1);
    chk("jalr_ok_wb_en", {31'd0, wb_enable}, 32'd1);
    drive(2'b10, 3'b000, 6'd0, 32'hFFFFFFFC, 32'h8, 32'h0, 5'd3);
    tick();
    chk("jal_wrap_wb_value", wb_value, 32'h0);
    chk("jal_wrap_target", target, 32'h4);
    chk("jal_wrap_redirect", {31'd0, redirect}, 32'd1);
    // 4: backpressure ordering A,B,C
    in_valid = 1'b0;
    tick();
    chk("drained", {31'd0, out_valid}, 32'd0);
    out_ready = 1'b0;
    drive(2'b00, 3'b000, 6'd0, 32'h0, 32'h0, 32'hA, 5'd2);
    tick();
    chk("a_in_ready", {31'd0, in_ready}, 32'd1);
    alu = 32'hB;
    tick();
    chk("b_in_ready_drop", {31'd0, in_ready}, 32'd0);
    alu = 32'hC;
    tick();
    chk("hold_a", wb_value, 32'hA);
    tick();
    chk("hold_a2", wb_value, 32'hA);
    chk("hold_in_ready", {31'd0, in_ready}, 32'd0);
    out_ready = 1'b1;
    tick();
    chk("order_b", wb_value, 32'hB);
    chk("order_b_in_ready", {31'd0, in_ready}, 32'd1);
    tick();
    chk("order_c", wb_value, 32'hC);
    chk("order_c_valid", {31'd0, out_valid}, 32'd1);
    in_valid = 1'b0;
    tick();
    chk("order_done", {31'd0, out_valid}, 32'd0);
    // 5: flush with two entries held
    out_ready = 1'b0;
    drive(2'b00, 3'b000, 6'd0, 32'h0, 32'h0, 32'hD, 5'd4);
    tick();
    alu = 32'hE;
    tick();
    chk("two_in_ready", {31'd0, in_ready}, 32'd0);
    flush = 1'b1; alu = 32'hF;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_valid", {31'd0, out_valid}, 32'd0);
    chk("flush_in_ready", {31'd0, in_ready}, 32'd1);
    out_ready = 1'b1;
    tick();
    chk("flush_no_emit", {31'd0, out_valid}, 32'd0);
    // 6: async reset while full
    out_ready = 1'b0;
    drive(2'b10, 3'b000, 6'd0, 32'h80, 32'h10, 32'h0, 5'd9);
    tick();
    tick();
    in_valid = 1'b0;
    chk("pre_rst_valid", {31'd0, out_valid}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", {31'd0, out_valid}, 32'd0);
    chk("arst_redirect", {31'd0, redirect}, 32'd0);
    chk("arst_wb_value", wb_value, 32'd0);
    chk("arst_in_ready", {31'd0, in_ready}, 32'd0);
    rst_n = 1'b1;
    tick();
    chk("rel_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rel_valid", {31'd0, out_valid}, 32'd0);
    out_ready = 1'b1;
    drive(2'b10, 3'b000, 6'd0, 32'h1000, 32'h20, 32'h0, 5'd0);
    tick();
    in_valid = 1'b0;
    chk("jal_rd0_wb_en", {31'd0, wb_enable}, 32'd0);
    chk("jal_rd0_redirect", {31'd0, redirect}, 32'd1);
    chk("jal_rd0_target", target, 32'h1020);
    chk("jal_rd0_wb_value", wb_value, 32'h1004);
    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
